stopwatch_control: RTL

Front-end control stage for the stopwatch datapath. It takes three raw, bouncing push-buttons (start, stop, clear) and synchronises and debounces each one. A three-state run/pause/idle machine then drives the `start_resume`, `stop` and counter-clear inputs of the cascaded modulo digit counters directly downstream. All outputs are registered, so the counter chain sees glitch-free, clock-aligned control levels.

---
 rtl/stopwatch_control.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_control.sv
// stopwatch_control
// Front-end control for the stopwatch datapath. Three raw push-buttons
// (start, stop, clear) are synchronised, debounced and edge-detected.
// A run/pause/idle machine then drives registered, glitch-free control
// levels into the cascaded digit counters.

module stopwatch_control #(
  parameter int DEB_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  output logic       start_resume,
  output logic       stop,
  output logic       clear,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  // Button lanes share one layout: bit 0 start, bit 1 stop, bit 2 clear.
  localparam int BtnStart = 0;
  localparam int BtnStop  = 1;
  localparam int BtnClear = 2;

  // A level change is accepted on the cycle the counter would reach DEB_LEN.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_LEN - 1);

  logic [2:0]       btnRaw;
  logic [2:0]       s1_q;
  logic [2:0]       s2_q;
  logic [2:0]       deb_q;
  logic [2:0]       deb_d;
  logic [2:0]       debPrev_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       press;

  state_e state_q;
  state_e state_d;
  logic   clear_d;
  logic   startResume_q;
  logic   stop_q;
  logic   clear_q;

  assign btnRaw = {btn_clear, btn_stop, btn_start};

  // Debouncer next state: count consecutive cycles where the synchronised
  // level disagrees with the accepted level; any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Input chain registers: two-flop synchroniser, debounced level, its
  // one-cycle-delayed copy for edge detection, and the debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      debPrev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= btnRaw;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      debPrev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Only rising edges of the debounced level count as presses.
  assign press = deb_q & ~debPrev_q;

  // Next-state logic: stop dominates in RUN, clear dominates start elsewhere.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press[BtnClear]) begin
          clear_d = 1'b1;
        end else if (press[BtnStart]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (press[BtnStop]) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (press[BtnClear]) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (press[BtnStart]) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and control outputs update together so the counters never see
  // a combinational glitch or a skewed start/stop pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      startResume_q <= 1'b0;
      stop_q        <= 1'b0;
      clear_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      startResume_q <= (state_d == RUN);
      stop_q        <= (state_d == PAUSE);
      clear_q       <= clear_d;
    end
  end

  assign state        = state_q;
  assign start_resume = startResume_q;
  assign stop         = stop_q;
  assign clear        = clear_q;

endmodule
